// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of preg numbers, 4-wide pop (alloc) at head, 4-wide push (free) at tail.
// Optional FREE_LIST_DUPCHK_EN: track membership and drop duplicate frees, compacting accepted lanes.
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_ARCH  = 32,
  parameter int PREG_W    = 6,
  parameter int WIDTH     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_alloc_count,
  output logic              o_alloc_ok,
  output logic [PREG_W-1:0] o_alloc_p0,
  output logic [PREG_W-1:0] o_alloc_p1,
  output logic [PREG_W-1:0] o_alloc_p2,
  output logic [PREG_W-1:0] o_alloc_p3,
  input  logic [2:0]        i_free_count,
  input  logic [PREG_W-1:0] i_free_p0,
  input  logic [PREG_W-1:0] i_free_p1,
  input  logic [PREG_W-1:0] i_free_p2,
  input  logic [PREG_W-1:0] i_free_p3,
  output logic [PREG_W:0]   o_num_free,
  output logic              o_err
);

  logic [PREG_W-1:0] mem [NUM_PREGS];
  logic [PREG_W-1:0] head;
  logic [PREG_W-1:0] tail;
  logic [PREG_W:0]   num_free;
  logic              err;

  logic [PREG_W-1:0] alloc_p [WIDTH];
  logic [PREG_W-1:0] free_p  [WIDTH];
  logic [PREG_W-1:0] wr_addr [WIDTH];
  logic [PREG_W-1:0] wr_data [WIDTH];
  logic [WIDTH-1:0]  wr_en;
  logic [2:0]        granted;
  logic [2:0]        accepted;
  logic [PREG_W+1:0] occ_sum;
  logic              overflow;
  logic              drop_all;
  logic              dup_err;

  assign free_p[0] = i_free_p0;
  assign free_p[1] = i_free_p1;
  assign free_p[2] = i_free_p2;
  assign free_p[3] = i_free_p3;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_read
      assign alloc_p[gi] = mem[head + PREG_W'(gi)];
    end
  endgenerate

  assign o_alloc_p0 = alloc_p[0];
  assign o_alloc_p1 = alloc_p[1];
  assign o_alloc_p2 = alloc_p[2];
  assign o_alloc_p3 = alloc_p[3];
  assign o_num_free = num_free;
  assign o_err      = err;

  // Grant looks only at registered occupancy; same-cycle frees are never bypassed.
  assign o_alloc_ok = (i_alloc_count <= 3'd4) && ({{(PREG_W-2){1'b0}}, i_alloc_count} <= num_free);
  assign granted    = o_alloc_ok ? i_alloc_count : 3'd0;
  assign occ_sum    = {1'b0, num_free} - (PREG_W+2)'(granted) + (PREG_W+2)'(i_free_count);
  assign overflow   = occ_sum > (PREG_W+2)'(NUM_PREGS);
  assign drop_all   = (i_free_count > 3'd4) || overflow;

`ifdef FREE_LIST_DUPCHK_EN
  logic [NUM_PREGS-1:0] in_list;
  logic [NUM_PREGS-1:0] in_list_next;

  always_comb begin
    logic valid;
    logic dup;
    wr_en        = '0;
    accepted     = '0;
    dup_err      = 1'b0;
    in_list_next = in_list;
    for (int k = 0; k < WIDTH; k++) begin
      wr_addr[k] = '0;
      wr_data[k] = free_p[k];
    end
    for (int k = 0; k < WIDTH; k++) begin
      if (3'(k) < granted) in_list_next[alloc_p[k]] = 1'b0;
    end
    // Duplicates are judged against the pre-edge membership and earlier lanes; survivors pack toward tail.
    for (int k = 0; k < WIDTH; k++) begin
      valid = 3'(k) < i_free_count;
      dup   = in_list[free_p[k]];
      for (int j = 0; j < k; j++) begin
        if ((3'(j) < i_free_count) && (free_p[j] == free_p[k])) dup = 1'b1;
      end
      if (valid && dup) dup_err = 1'b1;
      if (valid && !dup && !drop_all) begin
        wr_en[k]                  = 1'b1;
        wr_addr[k]                = tail + PREG_W'(accepted);
        accepted                  = accepted + 3'd1;
        in_list_next[free_p[k]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_PREGS; i++) in_list[i] <= (i >= NUM_ARCH);
    end else begin
      in_list <= in_list_next;
    end
  end
`else
  always_comb begin
    wr_en    = '0;
    dup_err  = 1'b0;
    accepted = drop_all ? 3'd0 : i_free_count;
    for (int k = 0; k < WIDTH; k++) begin
      wr_addr[k] = tail + PREG_W'(k);
      wr_data[k] = free_p[k];
      if ((3'(k) < i_free_count) && !drop_all) wr_en[k] = 1'b1;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_PREGS; i++)
        mem[i] <= (i < NUM_PREGS - NUM_ARCH) ? PREG_W'(NUM_ARCH + i) : '0;
      head     <= '0;
      tail     <= PREG_W'(NUM_PREGS - NUM_ARCH);
      num_free <= (PREG_W+1)'(NUM_PREGS - NUM_ARCH);
      err      <= 1'b0;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (wr_en[k]) mem[wr_addr[k]] <= wr_data[k];
      end
      head     <= head + PREG_W'(granted);
      tail     <= tail + PREG_W'(accepted);
      num_free <= num_free - (PREG_W+1)'(granted) + (PREG_W+1)'(accepted);
      err      <= err | (i_alloc_count > 3'd4) | drop_all | dup_err;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: queue-based reference model plus literal spot checks.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] alloc_count = '0;
  logic [2:0] free_count = '0;
  logic [5:0] free_p0 = '0, free_p1 = '0, free_p2 = '0, free_p3 = '0;
  logic       alloc_ok;
  logic [5:0] alloc_p0, alloc_p1, alloc_p2, alloc_p3;
  logic [6:0] num_free;
  logic       err;

  free_list dut (
    .i_clk(clk), .i_rst(rst),
    .i_alloc_count(alloc_count), .o_alloc_ok(alloc_ok),
    .o_alloc_p0(alloc_p0), .o_alloc_p1(alloc_p1), .o_alloc_p2(alloc_p2), .o_alloc_p3(alloc_p3),
    .i_free_count(free_count),
    .i_free_p0(free_p0), .i_free_p1(free_p1), .i_free_p2(free_p2), .i_free_p3(free_p3),
    .o_num_free(num_free), .o_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int q[$];
  int m_err;
  int act_ok, act_nf, act_err;
  int act_p[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passes++;
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 32; i < 64; i++) q.push_back(i);
    m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alloc_count = '0;
    free_count = '0;
    #1;
    model_reset();
    chk("rst_num_free", int'(num_free), 32);
    chk("rst_err", int'(err), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int in_model(input int v);
    foreach (q[i]) if (q[i] == v) return 1;
    return 0;
  endfunction

  // One cycle: drive, compare DUT against model, then advance the model across the edge.
  task automatic step(input int ac, input int fc,
                      input int f0 = 0, input int f1 = 0, input int f2 = 0, input int f3 = 0);
    int exp_ok, g, sz, dup;
    int fl[4];
    int acc[$];
    @(negedge clk);
    alloc_count = 3'(ac);
    free_count  = 3'(fc);
    free_p0 = 6'(f0); free_p1 = 6'(f1); free_p2 = 6'(f2); free_p3 = 6'(f3);
    #1;
    exp_ok = (ac <= 4 && ac <= q.size()) ? 1 : 0;
    act_ok = int'(alloc_ok);
    act_p[0] = int'(alloc_p0); act_p[1] = int'(alloc_p1);
    act_p[2] = int'(alloc_p2); act_p[3] = int'(alloc_p3);
    act_nf  = int'(num_free);
    act_err = int'(err);
    chk("alloc_ok", act_ok, exp_ok);
    for (int k = 0; k < 4; k++)
      if (k < q.size()) chk($sformatf("alloc_p%0d", k), act_p[k], q[k]);
    chk("num_free", act_nf, q.size());
    chk("err", act_err, m_err);
    @(posedge clk);
    g  = exp_ok ? ac : 0;
    sz = q.size();
    fl = '{f0, f1, f2, f3};
    if (ac > 4) m_err = 1;
    if (fc > 4 || sz - g + fc > 64) begin
      m_err = 1;
    end else begin
      for (int k = 0; k < fc; k++) begin
        dup = 0;
`ifdef FREE_LIST_DUPCHK_EN
        if (in_model(fl[k])) dup = 1;
        for (int j = 0; j < k; j++) if (fl[j] == fl[k]) dup = 1;
`endif
        if (dup) m_err = 1;
        else acc.push_back(fl[k]);
      end
    end
    repeat (g) void'(q.pop_front());
    foreach (acc[i]) q.push_back(acc[i]);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset view and first allocation.
    step(4, 0);
    chk("t1_ok", act_ok, 1);
    for (int k = 0; k < 4; k++) chk("t1_p", act_p[k], 32 + k);
    step(0, 0);
    for (int k = 0; k < 4; k++) chk("t1_next_p", act_p[k], 36 + k);
    chk("t1_num_free", act_nf, 28);

    // Drain to empty, then a denied request.
    repeat (7) step(4, 0);
    step(1, 0);
    chk("t2_num_free", act_nf, 0);
    chk("t2_ok", act_ok, 0);
    step(0, 0);
    chk("t2_err", act_err, 0);

    // Frees are not bypassed into a same-cycle grant.
    step(2, 3, 5, 9, 12);
    chk("t3_ok", act_ok, 0);
    step(3, 0);
    chk("t3_p0", act_p[0], 5);
    chk("t3_p1", act_p[1], 9);
    chk("t3_p2", act_p[2], 12);
    chk("t3_num_free", act_nf, 3);
    chk("t3_ok2", act_ok, 1);

    // Wrap: keep a few entries queued and cycle traffic so head crosses 63 -> 0 several times.
    step(0, 4, 20, 21, 22, 23);
    for (int i = 0; i < 60; i++) step(3, 3, (i * 3) % 64, (i * 3 + 1) % 64, (i * 3 + 2) % 64);
    step(4, 0);
    step(0, 0);

    // Illegal alloc count sets a sticky error.
    step(5, 0);
    chk("t5_ok", act_ok, 0);
    step(0, 0);
    chk("t5_err", act_err, 1);
    step(1, 1, 7);
    step(0, 0);
    chk("t5_sticky", act_err, 1);

    do_reset();
    step(0, 0);
    chk("t5_rst_err", act_err, 0);
    chk("t5_rst_nf", act_nf, 32);
    for (int k = 0; k < 4; k++) chk("t5_rst_p", act_p[k], 32 + k);

    // Fill to full, then overflow.
    for (int i = 0; i < 8; i++) step(0, 4, 4 * i, 4 * i + 1, 4 * i + 2, 4 * i + 3);
    step(0, 1, 0);
    chk("t5_full_nf", act_nf, 64);
    step(1, 4, 1, 2, 3, 4);
    chk("t5_ovf_err", act_err, 1);
    chk("t5_ovf_ok", act_ok, 1);
    step(0, 0);
    chk("t5_ovf_nf", act_nf, 63);
    step(0, 0);

`ifdef FREE_LIST_DUPCHK_EN
    do_reset();
    step(0, 1, 40);
    step(0, 0);
    chk("t6_err", act_err, 1);
    chk("t6_nf", act_nf, 32);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
